// File: rtl/multi_edge_detector_if.sv
// Bus bundle for multi_edge_detector: raw inputs and controls in, filtered
// levels, qualified edges and event accounting out.
interface multi_edge_detector_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]   signal;
    logic [2*WIDTH-1:0] mode;
    logic [WIDTH-1:0]   clear;
    logic               count_clr;
    logic [WIDTH-1:0]   level;
    logic [WIDTH-1:0]   edge_pulse;
    logic [WIDTH-1:0]   edge_sticky;
    logic [CNT_W-1:0]   event_count;
    logic               irq;

    modport master (
        output signal, mode, clear, count_clr,
        input  level, edge_pulse, edge_sticky, event_count, irq
    );

    modport slave (
        input  signal, mode, clear, count_clr,
        output level, edge_pulse, edge_sticky, event_count, irq
    );
endinterface

// File: rtl/multi_edge_detector.sv
// Multi-channel synchronise/debounce/edge-qualify block with sticky flags,
// a shared saturating event counter and an OR-reduced interrupt.
module med_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       sig,
    input  logic [1:0] mode,
    input  logic       clear,
    output logic       level,
    output logic       edge_pulse,
    output logic       edge_sticky,
    output logic       pulse_next
);
    localparam int DW = $clog2(DEBOUNCE + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          dcnt;
    logic                   sync;
    logic                   flip;

    assign sync = sync_q[SYNC_STAGES-1];
    // The flip edge is the only point where mode is consulted.
    assign flip       = (sync != level) && (dcnt == DW'(DEBOUNCE - 1));
    assign pulse_next = flip & ((sync & mode[0]) | (~sync & mode[1]));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            dcnt        <= '0;
            level       <= 1'b0;
            edge_pulse  <= 1'b0;
            edge_sticky <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
            if (sync == level) begin
                dcnt <= '0;
            end else if (flip) begin
                level <= sync;
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
            edge_pulse  <= pulse_next;
            edge_sticky <= pulse_next | (edge_sticky & ~clear);
        end
    end
endmodule

module multi_edge_detector #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input logic                  clock,
    input logic                  rst_n,
    multi_edge_detector_if.slave bus
);
    localparam int PW = $clog2(WIDTH + 1);
    localparam int SW = CNT_W + PW + 1;

    logic [WIDTH-1:0] pulse_next;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] edge_sticky;
    logic [CNT_W-1:0] event_count;
    logic [PW-1:0]    pop;
    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] cnt_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        med_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE)
        ) u_lane (
            .clock       (clock),
            .rst_n       (rst_n),
            .sig         (bus.signal[i]),
            .mode        (bus.mode[2*i+1:2*i]),
            .clear       (bus.clear[i]),
            .level       (level[i]),
            .edge_pulse  (edge_pulse[i]),
            .edge_sticky (edge_sticky[i]),
            .pulse_next  (pulse_next[i])
        );
    end

    // Wide sum so every simultaneous pulse counts before saturation.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + PW'(pulse_next[i]);
        if (bus.count_clr) sum = SW'(pop);
        else               sum = SW'(event_count) + SW'(pop);
        if (sum > SW'({CNT_W{1'b1}})) cnt_next = '1;
        else                           cnt_next = sum[CNT_W-1:0];
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) event_count <= '0;
        else        event_count <= cnt_next;
    end

    assign bus.level       = level;
    assign bus.edge_pulse  = edge_pulse;
    assign bus.edge_sticky = edge_sticky;
    assign bus.event_count = event_count;
    assign bus.irq         = |edge_sticky;
endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: phase table plus hand sequences for
// latency, glitch rejection, sticky priority, counter clear and async reset.
module tb_multi_edge_detector;
    localparam int W  = 8;
    localparam int CW = 3;

    logic clock;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    multi_edge_detector_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    multi_edge_detector #(
        .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE(4), .CNT_W(CW)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [W-1:0]   sig;
        logic [2*W-1:0] mode;
        logic [W-1:0]   clr;
        logic           cclr;
        int             hold;
        logic [W-1:0]   lvl;
        logic [W-1:0]   stk;
        logic [CW-1:0]  cnt;
    } vec_t;

    vec_t vecs[5];
    int   pcnt[W];
    logic [W-1:0] seen;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " level"},  32'(bus.level), 0);
        chk({nm, " pulse"},  32'(bus.edge_pulse), 0);
        chk({nm, " sticky"}, 32'(bus.edge_sticky), 0);
        chk({nm, " count"},  32'(bus.event_count), 0);
        chk({nm, " irq"},    32'(bus.irq), 0);
    endtask

    task automatic do_reset();
        bus.signal = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (8) step();
    endtask

    initial begin
        // phase table: mode-filter rows first, then saturation rows
        vecs[0] = '{8'h0F, 16'h00E4, 8'h00, 1'b0, 8, 8'h0F, 8'h0A, 3'd2};
        vecs[1] = '{8'h00, 16'h00E4, 8'h00, 1'b0, 8, 8'h00, 8'h0E, 3'd4};
        vecs[2] = '{8'h00, 16'h00E4, 8'hFF, 1'b1, 1, 8'h00, 8'h00, 3'd0};
        vecs[3] = '{8'hFF, 16'hFFFF, 8'h00, 1'b0, 8, 8'hFF, 8'hFF, 3'd7};
        vecs[4] = '{8'h00, 16'hFFFF, 8'h00, 1'b0, 8, 8'h00, 8'hFF, 3'd7};

        // reset with inputs high
        rst_n         = 1'b0;
        bus.signal    = 8'hFF;
        bus.mode      = 16'h0001;
        bus.clear     = '0;
        bus.count_clr = 1'b0;
        #1;
        chk_all_zero("reset_t0");
        step();
        step();
        chk_all_zero("reset_clocked");
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("rel_pulse_e%0d", k), 32'(bus.edge_pulse), (k == 6) ? 32'h01 : 32'h00);
            if (k == 6) begin
                chk("rel_level",  32'(bus.level), 32'hFF);
                chk("rel_count",  32'(bus.event_count), 1);
                chk("rel_irq",    32'(bus.irq), 1);
                chk("rel_sticky", 32'(bus.edge_sticky), 32'h01);
            end
        end

        // software clear of sticky and counter
        bus.clear = 8'hFF; bus.count_clr = 1'b1;
        step();
        bus.clear = '0; bus.count_clr = 1'b0;
        chk("clr_sticky", 32'(bus.edge_sticky), 0);
        chk("clr_count",  32'(bus.event_count), 0);
        chk("clr_irq",    32'(bus.irq), 0);

        // glitch reject on ch1, then accepted rise and fall
        do_reset();
        bus.mode = 16'h000C;
        bus.signal = 8'h02;
        repeat (3) step();
        bus.signal = 8'h00;
        seen = '0;
        for (int k = 0; k < 9; k++) begin
            step();
            seen |= bus.edge_pulse;
        end
        chk("glitch_pulse", 32'(seen), 0);
        chk("glitch_level", 32'(bus.level), 0);
        chk("glitch_count", 32'(bus.event_count), 0);
        bus.signal = 8'h02;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("hold_rise_e%0d", k), 32'(bus.edge_pulse), (k == 6) ? 32'h02 : 32'h00);
        end
        chk("hold_rise_level", 32'(bus.level), 32'h02);
        chk("hold_rise_count", 32'(bus.event_count), 1);
        bus.signal = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("hold_fall_e%0d", k), 32'(bus.edge_pulse), (k == 6) ? 32'h02 : 32'h00);
        end
        chk("hold_fall_level",  32'(bus.level), 0);
        chk("hold_fall_count",  32'(bus.event_count), 2);
        chk("hold_fall_sticky", 32'(bus.edge_sticky), 32'h02);

        // table phases
        do_reset();
        for (int i = 0; i < W; i++) pcnt[i] = 0;
        for (int r = 0; r < 5; r++) begin
            bus.signal    = vecs[r].sig;
            bus.mode      = vecs[r].mode;
            bus.clear     = vecs[r].clr;
            bus.count_clr = vecs[r].cclr;
            for (int c = 0; c < vecs[r].hold; c++) begin
                step();
                for (int i = 0; i < W; i++) pcnt[i] += int'(bus.edge_pulse[i]);
            end
            bus.clear     = '0;
            bus.count_clr = 1'b0;
            chk($sformatf("vec%0d_level", r),  32'(bus.level), 32'(vecs[r].lvl));
            chk($sformatf("vec%0d_sticky", r), 32'(bus.edge_sticky), 32'(vecs[r].stk));
            chk($sformatf("vec%0d_count", r),  32'(bus.event_count), 32'(vecs[r].cnt));
            chk($sformatf("vec%0d_irq", r),    32'(bus.irq), 32'(|vecs[r].stk));
            if (r == 1) begin
                chk("mode00_pulses", 32'(pcnt[0]), 0);
                chk("mode01_pulses", 32'(pcnt[1]), 1);
                chk("mode10_pulses", 32'(pcnt[2]), 1);
                chk("mode11_pulses", 32'(pcnt[3]), 2);
            end
        end

        // count_clr and clear[0] coinciding with two simultaneous pulses
        bus.signal = 8'h03;
        seen = '0;
        repeat (5) begin
            step();
            seen |= bus.edge_pulse;
        end
        chk("pre_pulse_quiet", 32'(seen), 0);
        bus.count_clr = 1'b1; bus.clear = 8'h01;
        step();
        bus.count_clr = 1'b0; bus.clear = 8'hFF;
        chk("cclr_pulse",  32'(bus.edge_pulse), 32'h03);
        chk("cclr_count",  32'(bus.event_count), 2);
        chk("set_wins",    32'(bus.edge_sticky), 32'hFF);
        step();
        bus.clear = '0;
        chk("clear_noevt", 32'(bus.edge_sticky), 0);
        chk("clear_irq",   32'(bus.irq), 0);
        chk("cnt_hold",    32'(bus.event_count), 2);

        // async reset mid-debounce with sticky set
        bus.signal = 8'h00;
        repeat (8) step();
        chk("pre_rst_sticky", 32'(bus.edge_sticky), 32'h03);
        chk("pre_rst_count",  32'(bus.event_count), 4);
        bus.signal = 8'hF0;
        repeat (3) step();
        rst_n = 1'b0;
        #2;
        chk_all_zero("async_rst");
        bus.signal = 8'h00;
        step();
        step();
        rst_n = 1'b1;
        seen = '0;
        repeat (10) begin
            step();
            seen |= bus.edge_pulse;
        end
        chk("post_rst_pulse", 32'(seen), 0);
        chk_all_zero("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
